// File: rtl/busy_table.sv
// Physical-register busy scoreboard between rename and issue.
// Tracks in-flight destinations and answers per-slot source pending bits.
module busy_table #(
  parameter int rwd  = 4,
  parameter int ewd  = 4,
  parameter int prsz = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [rwd-1:0]               ren_valid,
  input  logic [rwd-1:0]               ren_wen,
  input  logic [rwd-1:0][15:0]         ren_prda,
  input  logic [rwd-1:0][1:0][15:0]    ren_prsa,
  input  logic [rwd-1:0]               ren_accept,
  input  logic [ewd-1:0]               wb_valid,
  input  logic [ewd-1:0][15:0]         wb_prda,
  output logic [rwd-1:0][1:0]          busy_resp,
  output logic [$clog2(prsz):0]        busy_cnt
);

  localparam int aw = $clog2(prsz);
  localparam int cw = aw + 1;

  logic [prsz-1:0] busy;
  logic [prsz-1:0] clr;
  logic [prsz-1:0] set;
  logic [prsz-1:0] busy_nxt;
  logic [cw-1:0]   cnt_nxt;

  logic [rwd-1:0][aw-1:0]      dst;
  logic [rwd-1:0][1:0][aw-1:0] src;
  logic [ewd-1:0][aw-1:0]      wdst;

  always_comb begin
    for (int i = 0; i < rwd; i++) begin
      dst[i] = ren_prda[i][aw-1:0];
      for (int k = 0; k < 2; k++) begin
        src[i][k] = ren_prsa[i][k][aw-1:0];
      end
    end
    for (int j = 0; j < ewd; j++) begin
      wdst[j] = wb_prda[j][aw-1:0];
    end
  end

  // Upper address bits are architecturally ignored.
  generate
    if (aw < 16) begin : g_hi
      logic unused_hi;
      always_comb begin
        unused_hi = 1'b0;
        for (int i = 0; i < rwd; i++) begin
          unused_hi = unused_hi ^ (^ren_prda[i][15:aw]);
          for (int k = 0; k < 2; k++) begin
            unused_hi = unused_hi ^ (^ren_prsa[i][k][15:aw]);
          end
        end
        for (int j = 0; j < ewd; j++) begin
          unused_hi = unused_hi ^ (^wb_prda[j][15:aw]);
        end
      end
    end
  endgenerate

  always_comb begin
    clr = '0;
    for (int j = 0; j < ewd; j++) begin
      if (wb_valid[j]) begin
        clr[wdst[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    set = '0;
    for (int i = 0; i < rwd; i++) begin
      if (ren_valid[i] && ren_wen[i] && ren_accept[i]) begin
        set[dst[i]] = 1'b1;
      end
    end
    set[0] = 1'b0;
  end

  // Set applied after clear so a same-cycle re-allocation stays busy.
  always_comb begin
    busy_nxt    = (busy & ~clr) | set;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < prsz; r++) begin
      cnt_nxt = cnt_nxt + cw'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  logic [rwd-1:0][1:0] raw;
  logic [rwd-1:0][1:0] hit;

  // RAW against older slots ignores accept: the producer is ahead in order.
  always_comb begin
    raw = '0;
    hit = '0;
    for (int i = 0; i < rwd; i++) begin
      for (int k = 0; k < 2; k++) begin
        hit[i][k] = busy[src[i][k]] & ~clr[src[i][k]];
        for (int m = 0; m < i; m++) begin
          if (ren_valid[m] && ren_wen[m] && dst[m] == src[i][k]) begin
            raw[i][k] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    busy_resp = '0;
    for (int i = 0; i < rwd; i++) begin
      for (int k = 0; k < 2; k++) begin
        busy_resp[i][k] = ren_valid[i] &
                          (src[i][k] != '0) &
                          (hit[i][k] | raw[i][k]);
      end
    end
  end

endmodule

// File: tb/tb_busy_table.sv
// Randomized bench for busy_table against a set-based reference model.
// Directed scenarios first, then random bundles with occasional reset.
module tb_busy_table;

  localparam int rwd  = 4;
  localparam int ewd  = 4;
  localparam int prsz = 128;
  localparam int cw   = $clog2(prsz) + 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [rwd-1:0]            ren_valid;
  logic [rwd-1:0]            ren_wen;
  logic [rwd-1:0][15:0]      ren_prda;
  logic [rwd-1:0][1:0][15:0] ren_prsa;
  logic [rwd-1:0]            ren_accept;
  logic [ewd-1:0]            wb_valid;
  logic [ewd-1:0][15:0]      wb_prda;
  logic [rwd-1:0][1:0]       busy_resp;
  logic [cw-1:0]             busy_cnt;

  busy_table #(.rwd(rwd), .ewd(ewd), .prsz(prsz)) dut (
    .clk(clk),
    .rst(rst),
    .ren_valid(ren_valid),
    .ren_wen(ren_wen),
    .ren_prda(ren_prda),
    .ren_prsa(ren_prsa),
    .ren_accept(ren_accept),
    .wb_valid(wb_valid),
    .wb_prda(wb_prda),
    .busy_resp(busy_resp),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit mb[prsz];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int r = 0; r < prsz; r++) n += mb[r];
    return n;
  endfunction

  function automatic int pr(input logic [15:0] a);
    return int'(a) % prsz;
  endfunction

  task automatic idle();
    rst = 0; ren_valid = '0; ren_wen = '0; ren_prda = '0;
    ren_prsa = '0; ren_accept = '0; wb_valid = '0; wb_prda = '0;
  endtask

  // Inputs already driven; check responses, clock, check count.
  task automatic step();
    bit mclr[prsz];
    int s, e;
    bit exp;
    #1;
    for (int r = 0; r < prsz; r++) mclr[r] = 0;
    for (int j = 0; j < ewd; j++)
      if (wb_valid[j]) mclr[pr(wb_prda[j])] = 1;
    for (int i = 0; i < rwd; i++) begin
      if (!ren_valid[i]) continue;
      for (int k = 0; k < 2; k++) begin
        s = pr(ren_prsa[i][k]);
        exp = mb[s] && !mclr[s];
        for (int m = 0; m < i; m++)
          if (ren_valid[m] && ren_wen[m] && pr(ren_prda[m]) == s) exp = 1;
        if (s == 0) exp = 0;
        check("resp", int'(busy_resp[i][k]), int'(exp));
      end
    end
    if (rst) begin
      for (int r = 0; r < prsz; r++) mb[r] = 0;
    end else begin
      for (int r = 0; r < prsz; r++) if (mclr[r]) mb[r] = 0;
      for (int i = 0; i < rwd; i++) begin
        e = pr(ren_prda[i]);
        if (ren_valid[i] && ren_wen[i] && ren_accept[i] && e != 0)
          mb[e] = 1;
      end
    end
    @(posedge clk);
    #1;
    check("cnt", int'(busy_cnt), mcount());
  endtask

  task automatic alloc(input int slot, input int p);
    ren_valid[slot] = 1; ren_wen[slot] = 1;
    ren_accept[slot] = 1; ren_prda[slot] = 16'(p);
  endtask

  task automatic srcs(input int slot, input int a, input int b);
    ren_valid[slot] = 1;
    ren_prsa[slot][0] = 16'(a);
    ren_prsa[slot][1] = 16'(b);
  endtask

  initial begin
    int n;
    for (int r = 0; r < prsz; r++) mb[r] = 0;
    idle();
    @(posedge clk); #1;

    // reset with slot 0 allocating p5
    idle(); rst = 1; alloc(0, 5); step();
    idle(); rst = 1; alloc(0, 5); step();
    check("rst_cnt", int'(busy_cnt), 0);
    idle(); srcs(0, 5, 5); step();
    check("rst_p5", int'(busy_resp[0]), 0);

    // allocate p7 then read {7,3}
    idle(); alloc(0, 7); step();
    idle(); srcs(0, 7, 3); #1;
    check("alloc_resp", int'(busy_resp[0]), 1);
    check("alloc_cnt", int'(busy_cnt), 1);
    step();

    // writeback bypass of p7
    idle(); wb_valid[2] = 1; wb_prda[2] = 16'd7; srcs(1, 7, 0);
    #1; check("byp_resp", int'(busy_resp[1][0]), 0);
    step();
    check("byp_cnt", int'(busy_cnt), 0);

    // intra-bundle RAW on p9
    idle(); ren_valid[0] = 1; ren_wen[0] = 1; ren_prda[0] = 16'd9;
    ren_prsa[0][0] = 16'd9; srcs(2, 9, 0);
    #1;
    check("raw_resp", int'(busy_resp[2]), 1);
    check("raw_self", int'(busy_resp[0][0]), 0);
    step();

    // p0 dropped, unaccepted slot ignored
    n = int'(busy_cnt);
    idle(); alloc(0, 0); alloc(1, 12); ren_accept[1] = 0;
    srcs(2, 0, 0); step();
    check("p0_cnt", int'(busy_cnt), n);

    // set/clear collision on p20
    idle(); alloc(0, 20); step();
    n = int'(busy_cnt);
    idle(); alloc(0, 20); wb_valid[0] = 1; wb_prda[0] = 16'd20; step();
    check("coll_cnt", int'(busy_cnt), n);
    idle(); srcs(0, 20, 0); #1;
    check("coll_busy", int'(busy_resp[0][0]), 1);
    step();

    // fill every register
    for (int b = 1; b < prsz; b += rwd) begin
      idle();
      for (int i = 0; i < rwd; i++) if (b + i < prsz) alloc(i, b + i);
      step();
    end
    check("full_cnt", int'(busy_cnt), prsz - 1);
    idle(); alloc(0, 3); alloc(1, 64); step();
    check("full_hold", int'(busy_cnt), prsz - 1);

    // random bundles
    idle(); rst = 1; step();
    for (int c = 0; c < 400; c++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      n = $urandom_range(0, rwd);
      for (int i = 0; i < rwd; i++) begin
        ren_valid[i] = ($urandom_range(0, 3) != 0);
        ren_wen[i]   = $urandom_range(0, 1);
        ren_accept[i] = (i < n);
        ren_prda[i] = 16'(($urandom() & 16'hff80) | $urandom_range(0, 31));
        for (int k = 0; k < 2; k++)
          ren_prsa[i][k] = 16'(($urandom() & 16'hff80) | $urandom_range(0, 31));
      end
      for (int j = 0; j < ewd; j++) begin
        wb_valid[j] = $urandom_range(0, 1);
        wb_prda[j] = 16'(($urandom() & 16'hff80) | $urandom_range(0, 31));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/busy_table.md
Name: busy_table

Overview:
- Physical-register scoreboard between the rename stage and the issue queue.
- Marks a destination physical register busy when the rename stage accepts an allocating op, and clears it on execute writeback.
- Combinationally answers, per rename slot, whether each of the two source physical registers is still pending. These bits drive the issue queue's busy_resp input in the same cycle as the rename bundle.

Parameters:
- rwd, 4, rename width (slots per cycle)
- ewd, 4, execution/writeback width
- prsz, 128, number of physical registers (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ren_valid  in  [rwd-1:0]  slot holds a valid op (rename bundle opid[15])
- ren_wen  in  [rwd-1:0]  slot writes a destination register
- ren_prda  in  [rwd-1:0][15:0]  destination physical register address
- ren_prsa  in  [rwd-1:0][1:0][15:0]  source physical register addresses
- ren_accept  in  [rwd-1:0]  slot accepted downstream this cycle (issue-queue ready)
- wb_valid  in  [ewd-1:0]  writeback valid (execute bundle opid[15])
- wb_prda  in  [ewd-1:0][15:0]  writeback physical register address
- busy_resp  out  [rwd-1:0][1:0]  source k of slot i pending
- busy_cnt  out  [$clog2(prsz):0]  number of busy registers, registered

Behaviour:
- State: busy[prsz-1:0] bit vector plus registered busy_cnt.
- Addresses use only the low $clog2(prsz) bits; the upper bits are ignored.
- Physical register 0 is never busy. It is never set, it always reads 0, and a set request to p0 is dropped.
- Reset: busy = 0, busy_cnt = 0. busy_resp then depends only on the inputs. Reset asserted mid-operation overrides every set and clear in that cycle.
- Clear mask: clr[r] = OR over j of (wb_valid[j] & wb_prda[j] == r).
- Set mask: set[r] = OR over i of (ren_valid[i] & ren_wen[i] & ren_accept[i] & ren_prda[i] == r & r != 0).
- Next state: busy <= (busy & ~clr) | set. If set and clear hit the same register in one cycle, set wins.
- busy_cnt <= popcount of the next-state busy vector, so it matches busy every cycle.
- busy_resp[i][k] is purely combinational, zero latency. It is 1 iff src = ren_prsa[i][k] is nonzero and either:
  - (busy[src] & ~clr[src]), i.e. writeback bypass in the same cycle; or
  - some earlier slot m < i has ren_valid[m] & ren_wen[m] & ren_prda[m] == src (intra-bundle RAW). This term ignores ren_accept and clr.
- busy_resp for slots with ren_valid = 0 is don't-care; the implementation drives 0.
- ren_accept is assumed prefix-contiguous, because the issue queue accepts in order. Unaccepted slots must not modify state.
- Redirect needs no special handling. The issue queue drops ren_accept during a redirect. Registers of squashed producers stay busy until they are re-allocated and later written back.
- Multiple wb lanes hitting the same register: clear once; this is not an error.
- Multiple accepted slots naming the same prda: set once.
- No handshake stalls: the block is always ready.

Test Plan:
- Reset: hold rst 2 cycles with ren slot 0 allocating p5 -> busy_cnt = 0; busy_resp for source p5 = 0 after reset.
- Allocate then read: cycle 0, slot 0 accept, wen, prda = 7. Cycle 1, slot 0 prsa = {7, 3} -> busy_resp[0] = 2'b01, busy_cnt = 1.
- Writeback bypass: p7 busy; in one cycle wb_valid[2] with wb_prda = 7 and rename slot 1 sources p7 -> busy_resp[1][0] = 0 that cycle; next cycle busy_cnt = 0.
- Intra-bundle RAW: slot 0 wen prda = 9; slot 2 prsa = {9, 0}; p9 not busy in table -> busy_resp[2] = 2'b01. Slot 0 itself sourcing p9 -> 0.
- p0 and non-accept: slot 0 prda = 0 accepted and slot 1 prda = 12 with ren_accept[1] = 0 -> no state change, busy_cnt unchanged. Sourcing p0 always returns 0.
- Set/clear collision: p20 busy; wb clears p20 while an accepted slot re-allocates p20 -> p20 busy next cycle, busy_cnt unchanged. Then fill all prsz-1 registers -> busy_cnt = prsz-1 with no wrap.
